cam_subarray_ctrl: RTL and testbench
====================================

CAM_SUBARRAY_CTRL -- requirements
Module: cam_subarray_ctrl

Interface
REQ-001 SHALL have parameter SEARCH_LAT, default 1: cycles from search issue to valid tag_out (range 1..4).
REQ-002 SHALL have parameter SWEEP_W, default 5: width of the sweep count.
REQ-003 SHALL have port CLK, input, 1, the single clock; every flop uses its rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-005 SHALL have command ports, all inputs: cmd_valid 1, cmd_op 3, cmd_data 32, cmd_tag 32, cmd_cmp_addr 10, cmd_ppg_addr 6, cmd_cmp_data 2, cmd_ppg_data 2, cmd_addr_select 1, cmd_sweep SWEEP_W; plus cmd_ready, output, 1.
REQ-006 SHALL have response ports: rsp_valid output 1, rsp_ready input 1, rsp_tag output 32, rsp_err output 1.
REQ-007 SHALL have subarray-side outputs: data_in 32, update_signal 1, cmp_addr 10, ppg_addr 6, cmp_data 2, ppg_data 2, tag_in 32, addr_select 1, operation_mode 3, chip_enable 1; plus tag_out, input, 32.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-009 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&&cmd_ready and all cmd_* fields are registered.
- Transition: IDLE -> ISSUE.
REQ-010 SHALL, in ISSUE, drive registered fields onto subarray outputs with chip_enable=1 for exactly one cycle.
- update_signal=1 in ISSUE.
REQ-011 SHALL handle ops 000/001 (write/masked update) as follows:
- ISSUE -> RESP.
- Write commits on the edge ending ISSUE.
- rsp_tag=0.
REQ-012 SHALL handle ops 010..110 (searches) as follows:
- ISSUE -> WAIT.
- Hold subarray outputs and chip_enable=1 for SEARCH_LAT cycles.
- Sample tag_out on the last WAIT cycle.
REQ-013 SHALL handle op 111 (reserved) as follows:
- IDLE -> RESP directly.
- rsp_err=1, rsp_tag=0, chip_enable never asserted.
REQ-014 SHALL assert rsp_valid only in RESP and hold rsp_tag/rsp_err stable until rsp_valid&&rsp_ready.
- Then RESP -> IDLE.
- Back-to-back: earliest next acceptance is the cycle after the handshake.
REQ-015 SHALL drive chip_enable=0, update_signal=0 and operation_mode=000 outside ISSUE/WAIT.
- Data outputs retain last values.
REQ-016 SHALL give minimum latency, accept-to-rsp_valid, as follows:
- Writes: 2 cycles.
- Searches: 2+SEARCH_LAT cycles.
- Reserved: 1 cycle.

Reset
REQ-017 SHALL, on RST assertion, immediately force:
- State IDLE.
- All outputs 0, including cmd_ready, rsp_valid, chip_enable, rsp_tag, rsp_err.
REQ-018 SHALL assert cmd_ready on the first rising CLK after RST deasserts.
REQ-019 SHALL, on reset mid-operation, discard the in-flight command with no response.
- chip_enable drops asynchronously.

Configuration
REQ-020 SHALL support macro CAM_CTRL_SWEEP_EN.
REQ-021 SHALL, with CAM_CTRL_SWEEP_EN defined, run a sweep when a search has cmd_sweep=N>0:
- N+1 consecutive ISSUE/WAIT passes.
- cmp_addr[4:0] increments by 1 per pass, wrapping 31->0; cmp_addr[9:5] unchanged.
- rsp_tag = bitwise OR of all sampled tag_out.
- One response only.
REQ-022 SHALL, without CAM_CTRL_SWEEP_EN, ignore cmd_sweep (treated as 0); the sweep logic is absent.
REQ-023 SHALL, with CAM_CTRL_SWEEP_EN defined, ignore cmd_sweep for write and reserved ops.

Structure
REQ-024 SHALL place in shared package cam_pkg:
- Op encodings: OP_WRITE 000, OP_UPDATE 001, OP_SRCH_C 010, OP_SRCH_P 011, OP_SRCH_CC 100, OP_SRCH_PP 101, OP_SRCH_CP 110, OP_RSVD 111.
- FSM state type.
- Width constants: ROWS=36, COLS=32.
REQ-025 SHALL implement the address stepper/OR-accumulator as sub-module cam_ctrl_sweep, instantiated only under CAM_CTRL_SWEEP_EN.

Verification
REQ-026 SHALL cover write: op 000, data 0xFFFFFFFF, addr_select 1, rsp_ready=1.
- chip_enable high exactly 1 cycle; operation_mode=000 that cycle.
- rsp_valid 2 cycles after accept; rsp_tag 0, rsp_err 0.
REQ-027 SHALL cover search: op 010, cmp_addr 0x020, cmp_data 01, model tag_out=0xAAAAAAAA.
- rsp_tag=0xAAAAAAAA, 3 cycles after accept (SEARCH_LAT=1).
REQ-028 SHALL cover backpressure: hold rsp_ready=0 for 5 cycles during a search response.
- rsp_valid and rsp_tag stable.
- cmd_ready=0 throughout.
- IDLE one cycle after handshake.
REQ-029 SHALL cover reserved op 111.
- rsp_err=1 one cycle after accept.
- chip_enable never high.
REQ-030 SHALL cover reset in WAIT: assert RST mid-WAIT.
- chip_enable and all outputs 0 same cycle.
- No response.
- cmd_ready=1 after release.
REQ-031 SHALL cover sweep (CAM_CTRL_SWEEP_EN defined): op 010, cmp_addr[4:0]=30, sweep=3.
- Issued cmp_addr[4:0] = 30, 31, 0, 1.
- rsp_tag = OR of the four model tags.

Source files
------------

// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg -- shared definitions for the CAM subarray controller.
//   * Command op encodings (write/update, five search flavours, reserved).
//   * FSM state type and state constants.
//   * Array geometry: ROWS x COLS, plus the derived row-address width.
//   * is_search(): true for the five search ops.
// ---------------------------------------------------------------------------
package cam_pkg;

  localparam logic [2:0] OP_WRITE   = 3'b000;
  localparam logic [2:0] OP_UPDATE  = 3'b001;
  localparam logic [2:0] OP_SRCH_C  = 3'b010;
  localparam logic [2:0] OP_SRCH_P  = 3'b011;
  localparam logic [2:0] OP_SRCH_CC = 3'b100;
  localparam logic [2:0] OP_SRCH_PP = 3'b101;
  localparam logic [2:0] OP_SRCH_CP = 3'b110;
  localparam logic [2:0] OP_RSVD    = 3'b111;

  localparam int ROWS   = 36;
  localparam int COLS   = 32;
  localparam int PPG_AW = $clog2(ROWS);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;
  localparam state_t ST_RESP  = 2'd3;

  function automatic logic is_search(input logic [2:0] op);
    case (op)
      OP_SRCH_C, OP_SRCH_P, OP_SRCH_CC, OP_SRCH_PP, OP_SRCH_CP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cam_ctrl_sweep.sv
// ---------------------------------------------------------------------------
// cam_ctrl_sweep -- address stepper and tag OR-accumulator for sweep searches.
// Only instantiated when CAM_CTRL_SWEEP_EN is defined.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : command accepted; loads pass count, base address, clears OR
//   sweep_n    : extra passes after the first (0 = single pass)
//   base_lo    : cmp_addr[4:0] of the accepted command
//   pass_done  : last WAIT cycle of a pass (tag_out valid this cycle)
//   tag_out    : subarray match vector
//   addr_lo    : cmp_addr[4:0] to present for the current pass
//   last_pass  : the current pass is the final one
//   tag_or     : OR of all earlier passes' tags with the live tag_out
// ---------------------------------------------------------------------------
module cam_ctrl_sweep #(
  parameter int SWEEP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SWEEP_W-1:0] sweep_n,
  input  logic [4:0]         base_lo,
  input  logic               pass_done,
  input  logic [31:0]        tag_out,
  output logic [4:0]         addr_lo,
  output logic               last_pass,
  output logic [31:0]        tag_or
);

  logic [SWEEP_W-1:0] remain_reg;
  logic [4:0]         addr_lo_reg;
  logic [31:0]        acc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain_reg  <= '0;
      addr_lo_reg <= '0;
      acc_reg     <= '0;
    end else if (start) begin
      remain_reg  <= sweep_n;
      addr_lo_reg <= base_lo;
      acc_reg     <= '0;
    end else if (pass_done && !last_pass) begin
      // Address only steps between passes so it holds after the final one.
      remain_reg  <= remain_reg - SWEEP_W'(1);
      addr_lo_reg <= addr_lo_reg + 5'd1;
      acc_reg     <= acc_reg | tag_out;
    end
  end

  assign addr_lo   = addr_lo_reg;
  assign last_pass = (remain_reg == '0);
  assign tag_or    = acc_reg | tag_out;

endmodule

// File: rtl/cam_subarray_ctrl.sv
// ---------------------------------------------------------------------------
// cam_subarray_ctrl -- command/response front end for one CAM subarray.
// Build option: CAM_CTRL_SWEEP_EN enables multi-pass sweep searches.
//   CLK, RST         : clock, asynchronous active-high reset
//   cmd_*            : command channel (valid/ready), fields registered on accept
//   rsp_*            : response channel (valid/ready), tag + error flag
//   data_in..addr_select, operation_mode, chip_enable : subarray drive
//   tag_out          : subarray match vector, sampled on last WAIT cycle
// Flow: IDLE -> ISSUE -> RESP (write/update), IDLE -> ISSUE -> WAIT x
// SEARCH_LAT -> RESP (search), IDLE -> RESP (reserved op, error).
// ---------------------------------------------------------------------------
module cam_subarray_ctrl
  import cam_pkg::*;
#(
  parameter int SEARCH_LAT = 1,
  parameter int SWEEP_W    = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [COLS-1:0]    cmd_data,
  input  logic [31:0]        cmd_tag,
  input  logic [9:0]         cmd_cmp_addr,
  input  logic [PPG_AW-1:0]  cmd_ppg_addr,
  input  logic [1:0]         cmd_cmp_data,
  input  logic [1:0]         cmd_ppg_data,
  input  logic               cmd_addr_select,
  input  logic [SWEEP_W-1:0] cmd_sweep,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_tag,
  output logic               rsp_err,
  output logic [COLS-1:0]    data_in,
  output logic               update_signal,
  output logic [9:0]         cmp_addr,
  output logic [PPG_AW-1:0]  ppg_addr,
  output logic [1:0]         cmp_data,
  output logic [1:0]         ppg_data,
  output logic [31:0]        tag_in,
  output logic               addr_select,
  output logic [2:0]         operation_mode,
  output logic               chip_enable,
  input  logic [31:0]        tag_out
);

  localparam logic [2:0] LAT_LAST = 3'(SEARCH_LAT - 1);

  state_t              state_reg;
  logic                live_reg;
  logic [2:0]          op_reg;
  logic [2:0]          wait_cnt_reg;
  logic [COLS-1:0]     data_reg;
  logic [31:0]         tag_in_reg;
  logic [9:0]          cmp_addr_reg;
  logic [PPG_AW-1:0]   ppg_addr_reg;
  logic [1:0]          cmp_data_reg;
  logic [1:0]          ppg_data_reg;
  logic                addr_sel_reg;
  logic [31:0]         rsp_tag_reg;
  logic                rsp_err_reg;

  logic                accept;
  logic                pass_end;
  logic                final_pass;
  logic [31:0]         final_tag;

  // live_reg keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = (state_reg == ST_IDLE) && live_reg;
  assign accept    = cmd_valid && cmd_ready;
  assign pass_end  = (state_reg == ST_WAIT) && (wait_cnt_reg == LAT_LAST);

`ifdef CAM_CTRL_SWEEP_EN
  logic [4:0] sweep_addr_lo;
  logic       unused_cmp_lo;

  cam_ctrl_sweep #(.SWEEP_W(SWEEP_W)) u_sweep (
    .clk       (CLK),
    .rst       (RST),
    .start     (accept && (cmd_op != OP_RSVD)),
    .sweep_n   (is_search(cmd_op) ? cmd_sweep : '0),
    .base_lo   (cmd_cmp_addr[4:0]),
    .pass_done (pass_end),
    .tag_out   (tag_out),
    .addr_lo   (sweep_addr_lo),
    .last_pass (final_pass),
    .tag_or    (final_tag)
  );

  assign cmp_addr      = {cmp_addr_reg[9:5], sweep_addr_lo};
  assign unused_cmp_lo = ^cmp_addr_reg[4:0];
`else
  logic unused_sweep;

  assign cmp_addr     = cmp_addr_reg;
  assign final_pass   = 1'b1;
  assign final_tag    = tag_out;
  assign unused_sweep = ^cmd_sweep;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      live_reg     <= 1'b0;
      op_reg       <= '0;
      wait_cnt_reg <= '0;
      data_reg     <= '0;
      tag_in_reg   <= '0;
      cmp_addr_reg <= '0;
      ppg_addr_reg <= '0;
      cmp_data_reg <= '0;
      ppg_data_reg <= '0;
      addr_sel_reg <= 1'b0;
      rsp_tag_reg  <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            op_reg      <= cmd_op;
            rsp_tag_reg <= '0;
            rsp_err_reg <= (cmd_op == OP_RSVD);
            if (cmd_op == OP_RSVD) begin
              // Reserved op never touches the subarray; drive fields hold.
              state_reg <= ST_RESP;
            end else begin
              data_reg     <= cmd_data;
              tag_in_reg   <= cmd_tag;
              cmp_addr_reg <= cmd_cmp_addr;
              ppg_addr_reg <= cmd_ppg_addr;
              cmp_data_reg <= cmd_cmp_data;
              ppg_data_reg <= cmd_ppg_data;
              addr_sel_reg <= cmd_addr_select;
              state_reg    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_reg <= '0;
          if (op_reg == OP_WRITE || op_reg == OP_UPDATE) begin
            state_reg <= ST_RESP;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pass_end) begin
            if (final_pass) begin
              rsp_tag_reg <= final_tag;
              state_reg   <= ST_RESP;
            end else begin
              state_reg <= ST_ISSUE;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign chip_enable    = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT);
  assign update_signal  = (state_reg == ST_ISSUE);
  assign operation_mode = chip_enable ? op_reg : 3'b000;
  assign rsp_valid      = (state_reg == ST_RESP);
  assign rsp_tag        = rsp_tag_reg;
  assign rsp_err        = rsp_err_reg;
  assign data_in        = data_reg;
  assign tag_in         = tag_in_reg;
  assign ppg_addr       = ppg_addr_reg;
  assign cmp_data       = cmp_data_reg;
  assign ppg_data       = ppg_data_reg;
  assign addr_select    = addr_sel_reg;

endmodule

// File: tb/tb_cam_subarray_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_subarray_ctrl -- directed plus randomized transactions against a
// cycle-timeline reference model of the controller.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cam_subarray_ctrl;

  localparam int LAT = 1;
  localparam int SW  = 5;
`ifdef CAM_CTRL_SWEEP_EN
  localparam bit SWEEP_EN = 1'b1;
`else
  localparam bit SWEEP_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [31:0]   cmd_data = '0, cmd_tag = '0;
  logic [9:0]    cmd_cmp_addr = '0;
  logic [5:0]    cmd_ppg_addr = '0;
  logic [1:0]    cmd_cmp_data = '0, cmd_ppg_data = '0;
  logic          cmd_addr_select = 1'b0;
  logic [SW-1:0] cmd_sweep = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0]   rsp_tag;
  logic [31:0]   data_in, tag_in, tag_out = '0;
  logic          update_signal, addr_select, chip_enable;
  logic [9:0]    cmp_addr;
  logic [5:0]    ppg_addr;
  logic [1:0]    cmp_data, ppg_data;
  logic [2:0]    operation_mode;

  cam_subarray_ctrl #(.SEARCH_LAT(LAT), .SWEEP_W(SW)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_tag(cmd_tag), .cmd_cmp_addr(cmd_cmp_addr),
    .cmd_ppg_addr(cmd_ppg_addr), .cmd_cmp_data(cmd_cmp_data),
    .cmd_ppg_data(cmd_ppg_data), .cmd_addr_select(cmd_addr_select),
    .cmd_sweep(cmd_sweep),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err),
    .data_in(data_in), .update_signal(update_signal), .cmp_addr(cmp_addr),
    .ppg_addr(ppg_addr), .cmp_data(cmp_data), .ppg_data(ppg_data),
    .tag_in(tag_in), .addr_select(addr_select),
    .operation_mode(operation_mode), .chip_enable(chip_enable),
    .tag_out(tag_out)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data = '0;
  logic [9:0]  last_cmp  = '0;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  task automatic scramble();
    cmd_op          = 3'($urandom_range(0, 7));
    cmd_data        = $urandom;
    cmd_tag         = $urandom;
    cmd_cmp_addr    = 10'($urandom);
    cmd_ppg_addr    = 6'($urandom);
    cmd_cmp_data    = 2'($urandom);
    cmd_ppg_data    = 2'($urandom);
    cmd_addr_select = 1'($urandom);
    cmd_sweep       = SW'($urandom);
  endtask

  task automatic chk_active(input logic upd, input logic [2:0] op, input logic [9:0] ca);
    check("chip_enable_active", chip_enable, 1);
    check("update_signal", update_signal, upd);
    check("operation_mode", operation_mode, op);
    check("cmp_addr", cmp_addr, ca);
    check("rsp_valid_busy", rsp_valid, 0);
    check("cmd_ready_busy", cmd_ready, 0);
  endtask

  task automatic chk_resp(input logic [31:0] tg, input logic err);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_tag", rsp_tag, tg);
    check("rsp_err", rsp_err, err);
    check("chip_enable_resp", chip_enable, 0);
    check("update_signal_resp", update_signal, 0);
    check("operation_mode_resp", operation_mode, 0);
    check("cmd_ready_resp", cmd_ready, 0);
  endtask

  // One full transaction: accept, per-cycle subarray timeline, response with
  // 'stall' cycles of backpressure, then the idle cycle after the handshake.
  task automatic txn(input logic [2:0] op, input logic [31:0] data, input logic [31:0] tg,
                     input logic [9:0] ca, input logic [5:0] pa, input logic [1:0] cd,
                     input logic [1:0] pd, input logic as, input logic [SW-1:0] sw,
                     input logic [31:0] tag0, input int stall);
    bit srch;
    int passes;
    logic [31:0] exp_tag, ptag;
    logic [9:0] exp_ca;
    srch    = (op >= 3'b010) && (op <= 3'b110);
    passes  = srch ? (SWEEP_EN ? int'(sw) + 1 : 1) : 0;
    exp_tag = '0;
    exp_ca  = ca;

    @(posedge CLK); #1;
    cmd_op = op; cmd_data = data; cmd_tag = tg; cmd_cmp_addr = ca;
    cmd_ppg_addr = pa; cmd_cmp_data = cd; cmd_ppg_data = pd;
    cmd_addr_select = as; cmd_sweep = sw; cmd_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge CLK);
    check("cmd_ready_idle", cmd_ready, 1);
    check("chip_enable_idle", chip_enable, 0);
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    scramble();

    if (op == 3'b000 || op == 3'b001) begin
      tag_out = $urandom;
      @(negedge CLK);
      chk_active(1'b1, op, ca);
      check("data_in", data_in, data);
      check("tag_in", tag_in, tg);
      check("ppg_addr", ppg_addr, pa);
      check("cmp_data", cmp_data, cd);
      check("ppg_data", ppg_data, pd);
      check("addr_select", addr_select, as);
      @(posedge CLK); #1;
    end

    for (int p = 0; p < passes; p++) begin
      exp_ca = 10'((int'(ca) & 'h3E0) | ((int'(ca) + p) & 'h1F));
      ptag   = (p == 0) ? tag0 : $urandom;
      tag_out = $urandom;
      @(negedge CLK);
      chk_active(1'b1, op, exp_ca);
      if (p == 0) begin
        check("data_in_srch", data_in, data);
        check("cmp_data_srch", cmp_data, cd);
        check("tag_in_srch", tag_in, tg);
      end
      @(posedge CLK); #1;
      for (int w = 0; w < LAT; w++) begin
        tag_out = (w == LAT - 1) ? ptag : $urandom;
        @(negedge CLK);
        chk_active(1'b0, op, exp_ca);
        @(posedge CLK); #1;
      end
      exp_tag = exp_tag | ptag;
    end

    tag_out = $urandom;
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      chk_resp(exp_tag, op == 3'b111);
      @(posedge CLK); #1;
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    chk_resp(exp_tag, op == 3'b111);
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    if (op != 3'b111) begin
      last_data = data;
      last_cmp  = exp_ca;
    end
    @(negedge CLK);
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("data_in_retained", data_in, last_data);
    check("cmp_addr_retained", cmp_addr, last_cmp);
    $display("txn op=%0d sweep=%0d stall=%0d rsp_tag=0x%08h rsp_err=%0d", op, sw, stall, exp_tag, op == 3'b111);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_chip_enable", chip_enable, 0);
    check("reset_rsp_tag", rsp_tag, 0);
    check("reset_data_in", data_in, 0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("ready_before_first_edge", cmd_ready, 0);
    @(posedge CLK); #1;
    check("ready_after_reset", cmd_ready, 1);

    // Directed: write, search, backpressured search, reserved, sweep
    txn(3'b000, 32'hFFFF_FFFF, 32'h1234_5678, 10'h155, 6'h2A, 2'b10, 2'b01, 1'b1, '0, 32'h0, 0);
    txn(3'b010, 32'h0F0F_0F0F, 32'h0000_0001, 10'h020, 6'h05, 2'b01, 2'b00, 1'b0, '0, 32'hAAAA_AAAA, 0);
    txn(3'b010, 32'h3C3C_3C3C, 32'h0000_0002, 10'h0A1, 6'h11, 2'b11, 2'b10, 1'b1, '0, 32'h5A5A_0FF0, 5);
    txn(3'b111, 32'hDEAD_BEEF, 32'hCAFE_F00D, 10'h3FF, 6'h3F, 2'b11, 2'b11, 1'b1, SW'(2), 32'h0, 1);
    txn(3'b010, 32'h0000_0001, 32'h0000_0003, 10'h2BE, 6'h01, 2'b01, 2'b01, 1'b0, SW'(3), 32'h8000_0001, 0);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      txn(3'($urandom_range(0, 7)), $urandom, $urandom, 10'($urandom), 6'($urandom),
          2'($urandom), 2'($urandom), 1'($urandom), SW'($urandom_range(0, 3)),
          $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while a search sits in WAIT
    @(posedge CLK); #1;
    cmd_op = 3'b011; cmd_data = 32'h7777_7777; cmd_tag = 32'h9999_9999;
    cmd_cmp_addr = 10'h0C3; cmd_sweep = '0; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    tag_out = 32'hFFFF_0000;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("chip_enable_in_wait", chip_enable, 1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_chip_enable", chip_enable, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_update_signal", update_signal, 0);
    check("rst_operation_mode", operation_mode, 0);
    check("rst_data_in", data_in, 0);
    check("rst_tag_in", tag_in, 0);
    check("rst_cmp_addr", cmp_addr, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(posedge CLK); #1;
    check("rst_held_chip_enable", chip_enable, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("ready_after_release", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("no_rsp_after_reset", rsp_valid, 0);
    end
    $display("txn reset_in_wait discarded");
    rsp_ready = 1'b0;

    // Controller must be fully usable after the mid-flight reset
    last_data = '0;
    last_cmp  = '0;
    txn(3'b100, 32'h2468_ACE0, 32'h1357_9BDF, 10'h21F, 6'h09, 2'b10, 2'b11, 1'b1, SW'(1), 32'h00FF_00FF, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
